// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decoder.
// Handshakes: mem_req/mem_addr hold stable until mem_ack (one transfer per ack);
// instr/instr_pc transfer on a cycle where instr_valid && instr_ready are both high.
interface fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        busy;

    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid, busy,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid, busy,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: loads the reset vector, then prefetches bytes into a small FIFO
// for the decoder, with branch redirect and discard of an in-flight read.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] VEC_ADDR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master bus,
    output logic [1:0]  o_dbg_state
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {VEC_LO = 2'd0, VEC_HI = 2'd1, RUN = 2'd2} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_req, w_req_nxt;
    logic [15:0]   r_addr, w_addr_nxt;
    logic [15:0]   r_pc, w_pc_nxt;
    logic          r_discard, w_discard_nxt;
    logic [7:0]    r_fifo_data [DEPTH];
    logic [15:0]   r_fifo_pc   [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count, w_count_nxt;
    logic          w_ack, w_run, w_valid, w_push, w_pop, w_flush;

    assign w_ack   = r_req && bus.mem_ack;
    assign w_run   = (r_state == RUN);
    assign w_valid = w_run && (r_count != '0);
    assign w_flush = w_run && bus.redirect;
    assign w_push  = w_run && w_ack && !r_discard && !bus.redirect;
    assign w_pop   = w_valid && bus.instr_ready && !bus.redirect;

    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_addr_nxt    = r_addr;
        w_pc_nxt      = r_pc;
        w_discard_nxt = r_discard;
        if (w_flush) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
        case (r_state)
            VEC_LO: begin
                if (!r_req) begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = VEC_ADDR;
                end else if (w_ack) begin
                    w_pc_nxt[7:0] = bus.mem_rdata;
                    w_addr_nxt    = VEC_ADDR + 16'd1;
                    w_state_nxt   = VEC_HI;
                end
            end
            VEC_HI: begin
                if (!r_req) begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = VEC_ADDR + 16'd1;
                end else if (w_ack) begin
                    // FIFO is empty on entry to RUN, so the first fetch issues at once
                    w_pc_nxt[15:8] = bus.mem_rdata;
                    w_addr_nxt     = {bus.mem_rdata, r_pc[7:0]};
                    w_state_nxt    = RUN;
                end
            end
            RUN: begin
                if (bus.redirect) begin
                    w_pc_nxt = bus.redirect_pc;
                end else if (w_push) begin
                    w_pc_nxt = r_pc + 16'd1;
                end
                if (w_ack) begin
                    w_discard_nxt = 1'b0;
                end else if (bus.redirect && r_req) begin
                    w_discard_nxt = 1'b1;
                end
                // An open request stays frozen until acked; otherwise issue if space remains
                if (!r_req || w_ack) begin
                    w_req_nxt  = (w_count_nxt < DEPTH_C);
                    w_addr_nxt = w_pc_nxt;
                end
            end
            default: begin
                w_state_nxt = VEC_LO;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= VEC_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_pc      <= '0;
            r_discard <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else begin
            r_req     <= w_req_nxt;
            r_addr    <= w_addr_nxt;
            r_pc      <= w_pc_nxt;
            r_discard <= w_discard_nxt;
            r_count   <= w_count_nxt;
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_data[r_wptr] <= bus.mem_rdata;
                    r_fifo_pc[r_wptr]   <= r_pc;
                    r_wptr              <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
            end
        end
    end

    assign bus.mem_req     = r_req;
    assign bus.mem_addr    = r_addr;
    assign bus.instr       = r_fifo_data[r_rptr];
    assign bus.instr_pc    = r_fifo_pc[r_rptr];
    assign bus.instr_valid = w_valid;
    assign bus.busy        = !w_run;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle vector table for start-up/redirect/wrap, then a
// memory responder with an in-order scoreboard for throughput, backpressure and reset.
module tb_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic [1:0]  dbg_state;
    int          checks;
    int          failures;
    int          pops;
    int          p0;
    int          wait_cnt;
    int          lat;
    bit          mem_en;
    bit          rdy;
    bit          rd;
    bit          found;
    logic [15:0] rd_pc;
    logic [15:0] exp_q[$];

    fetch_unit_if bus ();

    fetch_unit #(.DEPTH(4), .VEC_ADDR(16'hFFFC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    typedef struct {
        logic        ack;
        logic [7:0]  rdata;
        logic        rdy;
        logic        rd;
        logic [15:0] rd_pc;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_busy;
        logic        e_valid;
        logic [7:0]  e_instr;
        logic [15:0] e_pc;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"},   bus.mem_req,     1'b0);
        chk({tag, "_busy"},  bus.busy,        1'b1);
        chk({tag, "_valid"}, bus.instr_valid, 1'b0);
        chk({tag, "_instr"}, bus.instr,       8'h00);
        chk({tag, "_pc"},    bus.instr_pc,    16'h0000);
        chk({tag, "_state"}, dbg_state,       2'd0);
    endtask

    // one cycle of driver + memory model + scoreboard, executed at the falling edge
    task automatic step();
        logic [15:0] e;
        @(negedge clk);
        bus.instr_ready = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rd_pc;
        if (rd) begin
            exp_q.delete();
            for (int i = 0; i < 128; i++) exp_q.push_back(rd_pc + 16'(i));
        end else if (bus.instr_valid && rdy) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", bus.instr_pc, e);
                chk("sb_data", bus.instr, mem_byte(e));
                pops++;
            end
        end
        if (bus.mem_req && mem_en) begin
            if (wait_cnt >= lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_byte(bus.mem_addr);
                wait_cnt      = 0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 8'h00;
                wait_cnt++;
            end
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'h00;
        end
        rd = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; pops = 0; wait_cnt = 0; lat = 0;
        mem_en = 1'b1; rdy = 1'b0; rd = 1'b0; rd_pc = '0; found = 1'b0;
        rst_n = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0;

        //          ack   rdata  rdy   rd    rd_pc     req   addr      busy  valid instr  pc
        vecs[0]  = '{1'b1, 8'h34, 1'b1, 1'b1, 16'h5555, 1'b1, 16'hFFFC, 1'b1, 1'b0, 8'h00, 16'h0000};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 16'h5555, 1'b1, 16'hFFFD, 1'b1, 1'b0, 8'h00, 16'h0000};
        vecs[2]  = '{1'b1, 8'h12, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFD, 1'b1, 1'b0, 8'h00, 16'h0000};
        vecs[3]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[4]  = '{1'b1, 8'hA1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b1, 8'hA0, 16'h1234};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1236, 1'b0, 1'b1, 8'hA1, 16'h1235};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h8000, 1'b1, 16'h1236, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[7]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1236, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[8]  = '{1'b1, 8'hB0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[9]  = '{1'b1, 8'hB1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h8001, 1'b0, 1'b1, 8'hB0, 16'h8000};
        vecs[10] = '{1'b1, 8'hC0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[11] = '{1'b1, 8'hC1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 8'hC0, 16'hFFFF};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b1, 8'hC1, 16'h0000};

        // reset state
        @(negedge clk);
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // vector table: vector fetch, streaming, discard, coincident redirect, wrap
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_req", i),   bus.mem_req,     vecs[i].e_req);
            chk($sformatf("v%0d_addr", i),  bus.mem_addr,    vecs[i].e_addr);
            chk($sformatf("v%0d_busy", i),  bus.busy,        vecs[i].e_busy);
            chk($sformatf("v%0d_valid", i), bus.instr_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_instr", i), bus.instr,    vecs[i].e_instr);
                chk($sformatf("v%0d_ipc", i),   bus.instr_pc, vecs[i].e_pc);
            end
            bus.mem_ack     = vecs[i].ack;
            bus.mem_rdata   = vecs[i].rdata;
            bus.instr_ready = vecs[i].rdy;
            bus.redirect    = vecs[i].rd;
            bus.redirect_pc = vecs[i].rd_pc;
        end
        chk("state_run", dbg_state, 2'd2);

        // zero-wait streaming: one byte per cycle
        rdy = 1'b1; rd = 1'b1; rd_pc = 16'h1234;
        step();
        repeat (6) step();
        p0 = pops;
        repeat (16) step();
        chk("throughput", pops - p0, 16);

        // backpressure: FIFO fills to depth, request drops
        rdy = 1'b0;
        repeat (10) step();
        chk("bp_req_low", bus.mem_req, 1'b0);
        chk("bp_valid", bus.instr_valid, 1'b1);
        mem_en = 1'b0; rdy = 1'b1;
        p0 = pops;
        repeat (8) step();
        chk("bp_depth", pops - p0, 4);
        chk("bp_refill_req", bus.mem_req, 1'b1);
        mem_en = 1'b1;
        repeat (10) step();
        chk("bp_resume", (pops - p0) > 4, 1'b1);

        // 3-cycle memory, redirect while 1236h is pending
        lat = 3; rd = 1'b1; rd_pc = 16'h1230;
        step();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (bus.mem_req && bus.mem_addr == 16'h1236) found = 1'b1;
        end
        chk("see_1236", found, 1'b1);
        rd = 1'b1; rd_pc = 16'h8000;
        step();
        step();
        chk("hold_req", bus.mem_req, 1'b1);
        chk("hold_addr", bus.mem_addr, 16'h1236);
        p0 = pops;
        repeat (40) step();
        chk("redir_pops", (pops - p0) >= 5, 1'b1);

        // reset mid-request with a late ack
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (bus.mem_req) found = 1'b1;
        end
        chk("pre_rst_req", found, 1'b1);
        #2;
        rst_n = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 8'h77;
        #1;
        check_reset_vals("arst");
        @(posedge clk);
        #1;
        check_reset_vals("arst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ack = 1'b0;
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("post_rst_req", bus.mem_req, 1'b1);
        chk("post_rst_addr", bus.mem_addr, 16'hFFFC);
        chk("post_rst_busy", bus.busy, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
